// File: rtl/adc_trigger_capture_pkg.sv
// Shared definitions for the triggered capture stage: default geometry and FSM states.
// The renderer imports this for AW and the trigger index (PRE_TRIG_DEF).
package adc_trigger_capture_pkg;

    localparam int DEPTH_DEF    = 1024;
    localparam int AW_DEF       = 10;
    localparam int PRE_TRIG_DEF = 128;
    localparam int TIMEOUT_DEF  = 65535;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_ARMED   = 3'd2,
        ST_POST    = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_e;

    function automatic logic is_busy(cap_state_e s);
        return (s == ST_PREFILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/adc_trigger_capture_if.sv
// Sample-stream, control and frame read-port bundle between ADC path, capture stage and renderer.
// sample_valid_i is a one-cycle strobe with no back-pressure: every cycle it is high, sample_data_i is consumed.
interface adc_trigger_capture_if #(
    parameter int AW = adc_trigger_capture_pkg::AW_DEF
);
    logic          sample_valid_i;
    logic [7:0]    sample_data_i;
    logic [7:0]    trig_level_i;
    logic          auto_mode_i;
    logic          arm_i;
    logic          release_i;
    logic          busy_o;
    logic          frame_ready_o;
    logic          trig_forced_o;
    logic [AW-1:0] rd_addr_i;
    logic [7:0]    rd_data_o;

    modport slave (
        input  sample_valid_i, sample_data_i, trig_level_i, auto_mode_i,
        input  arm_i, release_i, rd_addr_i,
        output busy_o, frame_ready_o, trig_forced_o, rd_data_o
    );

    modport master (
        output sample_valid_i, sample_data_i, trig_level_i, auto_mode_i,
        output arm_i, release_i, rd_addr_i,
        input  busy_o, frame_ready_o, trig_forced_o, rd_data_o
    );
endinterface

// File: rtl/adc_trigger_capture_dpram.sv
// Simple dual-port frame buffer: one write port, one registered read port, same clock.
// Only the read output register is reset; the array is left uninitialised so it maps to block RAM.
module adc_trigger_capture_dpram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule

// File: rtl/adc_trigger_capture.sv
// Triggered waveform capture: rising-edge level trigger with pre-trigger history, optional
// auto-mode forced trigger, and a frozen frame read back relative to the trigger position.
module adc_trigger_capture
    import adc_trigger_capture_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int PRE_TRIG = PRE_TRIG_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                  clk_100MHz,
    input  logic                  rst,
    adc_trigger_capture_if.slave  bus,
    output cap_state_e            dbg_state_o
);
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
    localparam int TW       = $clog2(TIMEOUT + 1);

    cap_state_e    state_q, state_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    prev_sample_q;
    logic          prev_valid_q, prev_valid_d;
    logic          forced_q, forced_d;
    logic          busy, wr_en, real_trig, timeout_hit, trig;
    logic [AW-1:0] rd_phys;

    assign busy        = is_busy(state_q);
    assign wr_en       = busy && bus.sample_valid_i;
    assign real_trig   = prev_valid_q && (prev_sample_q < bus.trig_level_i)
                         && (bus.sample_data_i >= bus.trig_level_i);
    assign timeout_hit = bus.auto_mode_i && (tcnt_q == TW'(TIMEOUT - 1));
    assign trig        = (state_q == ST_ARMED) && bus.sample_valid_i && (real_trig || timeout_hit);
    // Frame index 0 maps to base; AW-bit wrap gives the modulo for free.
    assign rd_phys     = base_q + bus.rd_addr_i;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        forced_d     = forced_q;
        prev_valid_d = prev_valid_q | wr_en;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm_i) begin
                    state_d      = ST_PREFILL;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                    forced_d     = 1'b0;
                end
            end
            ST_PREFILL: begin
                if (bus.sample_valid_i) begin
                    if (cnt_q == AW'(PRE_TRIG - 1)) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    base_d   = wr_ptr_q - AW'(PRE_TRIG);
                    forced_d = !real_trig;
                    cnt_d    = '0;
                    state_d  = (POST_LEN == 0) ? ST_DONE : ST_POST;
                end else if (bus.sample_valid_i && (tcnt_q != TW'(TIMEOUT))) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_POST: begin
                if (bus.sample_valid_i) begin
                    if (cnt_q == AW'(POST_LEN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.arm_i || bus.release_i) begin
                    state_d      = ST_PREFILL;
                    cnt_d        = '0;
                    prev_valid_d = 1'b0;
                    forced_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            base_q        <= '0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            forced_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            prev_valid_q <= prev_valid_d;
            forced_q     <= forced_d;
            if (wr_en) begin
                wr_ptr_q      <= wr_ptr_q + 1'b1;
                prev_sample_q <= bus.sample_data_i;
            end
        end
    end

    adc_trigger_capture_dpram #(
        .AW (AW),
        .DW (8)
    ) u_ram (
        .clk_i   (clk_100MHz),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.sample_data_i),
        .raddr_i (rd_phys),
        .rdata_o (bus.rd_data_o)
    );

    assign bus.busy_o        = busy;
    assign bus.frame_ready_o = (state_q == ST_DONE);
    assign bus.trig_forced_o = forced_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture: frame-level reference model plus hand-computed frame values.
`timescale 1ns/1ps
module tb_adc_trigger_capture;
    import adc_trigger_capture_pkg::*;

    localparam int DEPTH    = 1024;
    localparam int AW       = 10;
    localparam int PRE_TRIG = 128;
    localparam int TIMEOUT  = 16;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    localparam int PH_IDLE = 0, PH_PRE = 1, PH_ARM = 2, PH_POST = 3, PH_DONE = 4;

    // ---------------- clock / reset ----------------
    logic clk_100MHz = 1'b0;
    logic rst        = 1'b1;
    always #5 clk_100MHz = ~clk_100MHz;

    adc_trigger_capture_if #(.AW(AW)) bus();
    cap_state_e dbg_state;

    adc_trigger_capture #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .PRE_TRIG (PRE_TRIG),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame = the last DEPTH samples written when the capture closes.
    int         m_ph;
    int         m_pre_n, m_arm_n, m_post_n;
    bit         m_prev_v, m_forced, m_init = 1'b0;
    logic [7:0] m_prev;
    logic [7:0] hist [$];
    logic [7:0] frame [DEPTH];
    bit         m_rd_known;
    logic [7:0] m_rd;
    bit         real_x;

    task automatic close_frame();
        m_ph = PH_DONE;
        for (int i = 0; i < DEPTH; i++) frame[i] = hist[i];
    endtask

    always @(posedge clk_100MHz) begin
        if (rst) begin
            m_init     = 1'b1;
            m_ph       = PH_IDLE;
            m_forced   = 1'b0;
            m_prev_v   = 1'b0;
            m_rd_known = 1'b1;
            m_rd       = 8'd0;
        end else if (m_init) begin
            m_rd_known = (m_ph == PH_DONE);
            if (m_rd_known) m_rd = frame[bus.rd_addr_i];
            case (m_ph)
                PH_IDLE: if (bus.arm_i) begin
                    m_ph = PH_PRE; m_pre_n = 0; m_prev_v = 1'b0;
                end
                PH_DONE: if (bus.arm_i || bus.release_i) begin
                    m_ph = PH_PRE; m_pre_n = 0; m_prev_v = 1'b0; m_forced = 1'b0;
                end
                default: if (bus.sample_valid_i) begin
                    hist.push_back(bus.sample_data_i);
                    if (hist.size() > DEPTH) void'(hist.pop_front());
                    if (m_ph == PH_PRE) begin
                        m_pre_n++;
                        if (m_pre_n == PRE_TRIG) begin m_ph = PH_ARM; m_arm_n = 0; end
                    end else if (m_ph == PH_ARM) begin
                        real_x = m_prev_v && (m_prev < bus.trig_level_i)
                                 && (bus.sample_data_i >= bus.trig_level_i);
                        m_arm_n++;
                        if (real_x || (bus.auto_mode_i && m_arm_n == TIMEOUT)) begin
                            m_forced = !real_x;
                            m_post_n = 0;
                            m_ph     = PH_POST;
                        end
                    end else begin
                        m_post_n++;
                        if (m_post_n == POST_LEN) close_frame();
                    end
                    m_prev   = bus.sample_data_i;
                    m_prev_v = 1'b1;
                end
            endcase
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk_100MHz) begin
        if (m_init) begin
            chk("busy", bus.busy_o, (m_ph == PH_PRE || m_ph == PH_ARM || m_ph == PH_POST));
            chk("frame_ready", bus.frame_ready_o, (m_ph == PH_DONE));
            chk("trig_forced", bus.trig_forced_o, m_forced);
            if (m_rd_known) chk("rd_data_model", bus.rd_data_o, m_rd);
        end
    end

    // ---------------- driver tasks ----------------
    int  n_gen = 0;
    int  gen_mode = 0;
    int  cyc = 0;
    bit  gaps_on = 1'b1;

    function automatic logic [7:0] gen(input int n);
        case (gen_mode)
            0:       return 8'(n % 256);
            1:       return 8'd50;
            default: return 8'(n % 255);
        endcase
    endfunction

    task automatic tick();
        @(negedge clk_100MHz);
        cyc++;
    endtask

    task automatic push(input logic [7:0] d);
        if (gaps_on && (cyc % 5 == 3)) begin
            bus.sample_valid_i = 1'b0;
            tick();
        end
        bus.sample_valid_i = 1'b1;
        bus.sample_data_i  = d;
        n_gen++;
        tick();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic feed(input int count);
        for (int i = 0; i < count; i++) push(gen(n_gen));
    endtask

    task automatic pulse(input bit a, input bit r);
        bus.sample_valid_i = 1'b0;
        bus.arm_i = a;
        bus.release_i = r;
        tick();
        bus.arm_i = 1'b0;
        bus.release_i = 1'b0;
    endtask

    task automatic read_lit(input int addr, input logic [7:0] exp, input string name);
        bus.sample_valid_i = 1'b0;
        bus.rd_addr_i = AW'(addr);
        tick();
        chk(name, bus.rd_data_o, exp);
    endtask

    task automatic run_to_done(input int budget, input string name);
        int k = 0;
        while (!bus.frame_ready_o && k < budget) begin
            feed(1);
            k++;
        end
        chk(name, bus.frame_ready_o, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid_i = 1'b0;
        bus.sample_data_i  = 8'd0;
        bus.trig_level_i   = 8'd100;
        bus.auto_mode_i    = 1'b0;
        bus.arm_i          = 1'b0;
        bus.release_i      = 1'b0;
        bus.rd_addr_i      = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_frame_ready", bus.frame_ready_o, 1'b0);
        chk("rst_trig_forced", bus.trig_forced_o, 1'b0);
        chk("rst_rd_data", bus.rd_data_o, 8'd0);
        chk("rst_state", dbg_state, ST_IDLE);

        // Test 1: ramp, level 100; crossing at 100 in PREFILL ignored, trigger on sample 356.
        gen_mode = 0; n_gen = 0;
        pulse(1'b1, 1'b0);
        feed(356);
        chk("t1_armed_busy", bus.busy_o, 1'b1);
        feed(1 + POST_LEN - 1);
        chk("t1_not_ready", bus.frame_ready_o, 1'b0);
        feed(1);
        chk("t1_ready", bus.frame_ready_o, 1'b1);
        chk("t1_busy_low", bus.busy_o, 1'b0);
        read_lit(128, 8'd100, "t1_rd128");
        read_lit(127, 8'd99, "t1_rd127");
        read_lit(0, 8'd228, "t1_rd0");
        read_lit(1023, 8'd227, "t1_rd1023");

        // Test 2: constant 50, auto mode forces trigger on the 16th ARMED sample.
        bus.auto_mode_i = 1'b1; gen_mode = 1;
        pulse(1'b1, 1'b0);
        feed(PRE_TRIG + TIMEOUT - 1);
        chk("t2_pre_timeout_busy", bus.busy_o, 1'b1);
        feed(1 + POST_LEN - 1);
        chk("t2_not_ready", bus.frame_ready_o, 1'b0);
        feed(1);
        chk("t2_ready", bus.frame_ready_o, 1'b1);
        chk("t2_forced", bus.trig_forced_o, 1'b1);
        read_lit(0, 8'd50, "t2_rd0");
        read_lit(128, 8'd50, "t2_rd128");
        read_lit(1023, 8'd50, "t2_rd1023");

        // Test 3: no auto mode, stays ARMED; stray release ignored; then a real crossing.
        bus.auto_mode_i = 1'b0;
        pulse(1'b1, 1'b0);
        chk("t3_forced_cleared", bus.trig_forced_o, 1'b0);
        feed(PRE_TRIG + 10 * TIMEOUT);
        chk("t3_busy", bus.busy_o, 1'b1);
        chk("t3_not_ready", bus.frame_ready_o, 1'b0);
        pulse(1'b0, 1'b1);
        chk("t3_release_ignored", bus.busy_o, 1'b1);
        push(8'd120);
        feed(POST_LEN - 1);
        chk("t3_post_not_ready", bus.frame_ready_o, 1'b0);
        feed(1);
        chk("t3_ready", bus.frame_ready_o, 1'b1);
        chk("t3_real", bus.trig_forced_o, 1'b0);
        read_lit(128, 8'd120, "t3_rd128");
        read_lit(127, 8'd50, "t3_rd127");
        read_lit(129, 8'd50, "t3_rd129");

        // Test 5: release re-arms; new ramp frame completes.
        pulse(1'b0, 1'b1);
        chk("t5_ready_drop", bus.frame_ready_o, 1'b0);
        chk("t5_busy", bus.busy_o, 1'b1);
        gen_mode = 0; n_gen = 0;
        run_to_done(3000, "t5_done");
        read_lit(128, 8'd100, "t5_rd128");
        read_lit(127, 8'd99, "t5_rd127");
        read_lit(0, 8'd228, "t5_rd0");

        // arm + release together: a single restart.
        pulse(1'b1, 1'b1);
        chk("ar_ready_drop", bus.frame_ready_o, 1'b0);
        chk("ar_busy", bus.busy_o, 1'b1);
        n_gen = 0;
        feed(356 + 1 + 10);
        chk("t6_in_post", bus.busy_o, 1'b1);

        // Test 6: reset during POST with arm also high.
        rst = 1'b1; bus.arm_i = 1'b1;
        bus.sample_valid_i = 1'b1; bus.sample_data_i = gen(n_gen);
        tick();
        chk("t6_busy", bus.busy_o, 1'b0);
        chk("t6_ready", bus.frame_ready_o, 1'b0);
        chk("t6_rd", bus.rd_data_o, 8'd0);
        rst = 1'b0; bus.arm_i = 1'b0; bus.sample_valid_i = 1'b0;
        repeat (3) tick();
        chk("t6_idle_busy", bus.busy_o, 1'b0);
        chk("t6_idle_state", dbg_state, ST_IDLE);

        // Test 4: trigger sample lands on wr_ptr=5 (1029 writes since reset); frame wraps physically.
        gaps_on = 1'b0; gen_mode = 2; n_gen = 0;
        bus.trig_level_i = 8'd255;
        pulse(1'b1, 1'b0);
        feed(1029);
        chk("t4_busy", bus.busy_o, 1'b1);
        push(8'd255);
        feed(POST_LEN - 1);
        chk("t4_not_ready", bus.frame_ready_o, 1'b0);
        feed(1);
        chk("t4_ready", bus.frame_ready_o, 1'b1);
        for (int a = 0; a < DEPTH; a++) begin
            read_lit(a, (a == PRE_TRIG) ? 8'd255 : 8'((901 + a) % 255), "t4_sweep");
        end
        read_lit(122, 8'd3, "t4_rd122");
        read_lit(123, 8'd4, "t4_rd123_wrap");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
